// File: rtl/sdram_port_arb_if.sv
// Single-request bus between the port arbiter and the sdram controller.
// mem_rdata is valid in the same cycle as the one-cycle mem_ack pulse.
interface sdram_port_arb_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Shares the sdram request port between ioctl download writes and the CPU.
// Download writes have strict priority; the CPU is held off during a download.
module sdram_port_arb #(
  parameter int AW = 25,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          i_ioctl_download,
  input  logic          i_ioctl_wr,
  input  logic [AW-1:0] i_ioctl_addr,
  input  logic [DW-1:0] i_ioctl_dout,
  output logic          o_ioctl_wait,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [1:0]    i_cpu_be,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_hold,
  sdram_port_arb_if.master mem,
  output logic [AW-1:0] o_dl_words,
  output logic          o_dl_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DL_ISSUE,
    CPU_ISSUE,
    CPU_DONE
  } state_t;

  state_t        r_state;
  logic          r_hold_v;
  logic [AW-1:0] r_hold_addr;
  logic [DW-1:0] r_hold_data;
  logic          r_overrun;
  logic          r_dl_prev;
  logic [AW-1:0] r_dl_words;
  logic          r_cpu_hold;
  logic          r_cpu_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [1:0]    r_mem_be;
  logic [DW-1:0] r_mem_wdata;

  logic w_hold_clr;
  logic w_hold_free;
  logic w_dl_rise;
  logic w_dl_done;

  // hold empties on the same edge it is moved into the mem regs
  assign w_hold_clr  = (r_state == IDLE) && r_hold_v;
  assign w_hold_free = !r_hold_v || w_hold_clr;
  assign w_dl_rise   = i_ioctl_download && !r_dl_prev;
  assign w_dl_done   = (r_state == DL_ISSUE) && mem.mem_ack;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      r_hold_v    <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_overrun   <= 1'b0;
      r_dl_prev   <= 1'b0;
      r_dl_words  <= '0;
      r_cpu_hold  <= 1'b0;
    end else begin
      if (i_ioctl_wr && w_hold_free) begin
        r_hold_v    <= 1'b1;
        r_hold_addr <= i_ioctl_addr & ~AW'(1);
        r_hold_data <= i_ioctl_dout;
      end else if (w_hold_clr) begin
        r_hold_v    <= 1'b0;
      end
      if (i_ioctl_wr && !w_hold_free)
        r_overrun <= 1'b1;
      r_dl_prev <= i_ioctl_download;
      if (w_dl_rise)
        r_dl_words <= '0;
      else if (w_dl_done)
        r_dl_words <= r_dl_words + AW'(1);
      r_cpu_hold <= i_ioctl_download | r_hold_v |
                    (r_state == DL_ISSUE);
    end
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_hold_v) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_hold_addr;
            r_mem_be    <= 2'b11;
            r_mem_wdata <= r_hold_data;
            r_state     <= DL_ISSUE;
          end else if (i_cpu_req && !r_cpu_hold) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_cpu_we;
            r_mem_addr  <= i_cpu_addr;
            r_mem_be    <= i_cpu_be;
            r_mem_wdata <= i_cpu_wdata;
            r_state     <= CPU_ISSUE;
          end
        end
        DL_ISSUE: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        CPU_ISSUE: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we)
              r_cpu_rdata <= mem.mem_rdata;
            r_cpu_ack <= 1'b1;
            r_state   <= CPU_DONE;
          end
        end
        CPU_DONE: begin
          r_cpu_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign o_ioctl_wait  = r_hold_v | (r_state == DL_ISSUE);
  assign o_cpu_ack     = r_cpu_ack;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_cpu_hold    = r_cpu_hold;
  assign o_dl_words    = r_dl_words;
  assign o_dl_overrun  = r_overrun;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
Shares the single request port of the SDRAM controller between two requesters: the ioctl download path, which loads ROM/BIOS images as 16-bit writes, and the CPU bus, which issues reads and writes. Download writes have strict priority. The CPU is held off while a download is active. Sits in mycore between the ioctl/CPU logic and the sdram controller instance.

Parameters:
AW, 25, byte address width shared by all ports
DW, 16, data width (two byte lanes)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-low reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle write strobe
ioctl_addr  in  AW  download byte address; bit 0 ignored
ioctl_dout  in  DW  download write data
ioctl_wait  out  1  download must not advance its address
cpu_req  in  1  level request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU byte address
cpu_be  in  2  CPU byte enables
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_ack is high
cpu_hold  out  1  CPU must stay stalled/reset
mem_req  out  1  request to sdram controller
mem_we  out  1  write select
mem_addr  out  AW  byte address
mem_be  out  2  byte enables
mem_wdata  out  DW  write data
mem_ack  in  1  one-cycle done pulse; mem_rdata valid in the same cycle
mem_rdata  in  DW  read data
dl_words  out  AW  count of download writes completed
dl_overrun  out  1  sticky: an ioctl_wr was dropped

Behaviour:
- Reset: every output is 0, FSM is IDLE, the holding register is empty. Reset acts asynchronously at any time, including mid-transaction. An in-flight mem transaction is abandoned; the sdram controller shares this reset domain.
- Download holding register (hold_v, hold_addr, hold_data):
  - ioctl_wr captures ioctl_addr with bit 0 forced to 0, plus ioctl_dout, and sets hold_v on that edge.
  - If hold_v is already 1 and is not being cleared in that cycle, the write is dropped and dl_overrun is set (sticky until reset).
- ioctl_wait = hold_v OR (state == DL_ISSUE), driven from registers. It is high on the cycle after the ioctl_wr edge.
- FSM states: IDLE, DL_ISSUE, CPU_ISSUE, CPU_DONE.
  - IDLE:
    - If hold_v = 1: load the mem regs from hold (we=1, be=11), clear hold_v, set mem_req, go to DL_ISSUE.
    - Else if cpu_req = 1 and cpu_hold = 0: load the mem regs from the CPU inputs, set mem_req, go to CPU_ISSUE.
    - If both are eligible in the same cycle, download wins.
  - DL_ISSUE: mem_* held stable. On mem_ack: clear mem_req on that edge, increment dl_words, return to IDLE.
  - CPU_ISSUE: mem_* held stable. On mem_ack: clear mem_req, latch mem_rdata into cpu_rdata (reads only), go to CPU_DONE.
  - CPU_DONE: cpu_ack = 1 for exactly this cycle, then IDLE. cpu_req must drop by the cycle after cpu_ack; the arbiter does not re-accept a request in CPU_DONE.
- A CPU transaction already issued always completes, even if ioctl_download rises. Download writes arriving meanwhile wait in hold.
- An ioctl_wr in the same cycle as the mem_ack that retires a download write is captured normally (no overrun).
- cpu_hold = ioctl_download OR hold_v OR (state == DL_ISSUE), registered. It falls one cycle after the last download write completes with ioctl_download low.
- dl_words:
  - Clears on the rising edge of ioctl_download.
  - Increments once per retired download write, wrapping modulo 2^AW.
  - Holds its value after the download ends.
- mem_req never drops without a mem_ack, except on reset.
- Latency:
  - ioctl_wr to mem_req: 2 cycles.
  - cpu_req (IDLE) to mem_req: 1 cycle.
  - mem_ack to cpu_ack: 1 cycle.

Test Plan:
- Reset mid DL_ISSUE (mem_req=1), release: all outputs 0, FSM IDLE, no mem_ack needed.
- Download of 4 words: ioctl_wr with addr 0x000000/2/4/6, data 0x1234/0x5678/0x9ABC/0xDEF0, mem_ack 3 cycles after each mem_req → four mem writes with be=11 and matching addr/data; dl_words=4; ioctl_wait high from each wr until its ack; dl_overrun=0.
- Odd address: ioctl_addr=0x000101 → mem_addr=0x000100.
- Contention: cpu_req (read 0x100000) and ioctl_wr in the same IDLE cycle with ioctl_download=1 → download write issued first; CPU read not issued while cpu_hold=1; after ioctl_download falls, the read issues; mem_rdata=0xA5A5 → cpu_rdata=0xA5A5 with a 1-cycle cpu_ack.
- In-flight CPU write (addr 0x000200, be=01, data 0x00FF), then ioctl_download rises plus ioctl_wr → CPU write completes with cpu_ack, then the download write issues; dl_words=1.
- Two ioctl_wr 1 cycle apart while mem_ack is withheld → second is captured, a third is dropped, dl_overrun=1 and stays 1.
